str_gen: RTL and testbench

Stimulus-side string generator for the character-class checker variants. It emits a framed byte string on a valid/ready stream: 0x00, a run of digits, one math symbol, a run of capital letters, then 0x00. Run lengths are configurable, and one payload byte can be corrupted on request. Alongside the stream it outputs a golden `expect_ok` flag, so the bench and the board self-test can compare the checker's verdict against the prediction without a software model.

---
 rtl/evm_str_pkg.sv | 41 ++++
 rtl/lfsr16.sv | 18 +
 rtl/str_gen.sv | 102 ++++++++++
 tb/tb_str_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/evm_str_pkg.sv
// rtl/evm_str_pkg.sv - states, character constants and predictor limits for str_gen
package evm_str_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DIG,
        S_OP,
        S_CAP,
        S_EOF
    } state_t;

    localparam logic [7:0] NUL        = 8'h00;
    localparam logic [7:0] ERR_CHAR   = 8'h23;
    localparam logic [7:0] DIGIT_BASE = 8'h30;
    localparam logic [7:0] CAP_BASE   = 8'h41;

    // Element 0 is the rightmost: + - * / \ = < >
    localparam logic [7:0][7:0] MATH_TAB = {8'h3E, 8'h3C, 8'h3D, 8'h5C,
                                            8'h2F, 8'h2A, 8'h2D, 8'h2B};

    localparam logic [2:0] NUM_MIN = 3'd3;
    localparam logic [2:0] NUM_MAX = 3'd5;
    localparam logic [2:0] CAP_MIN = 3'd1;
    localparam logic [2:0] CAP_MAX = 3'd4;

    function automatic logic [7:0] digit_char(input logic [15:0] r);
        return DIGIT_BASE + {5'd0, r[2:0]};
    endfunction

    function automatic logic [7:0] cap_char(input logic [15:0] r);
        logic [4:0] v;
        v = (r[4:0] >= 5'd26) ? r[4:0] - 5'd26 : r[4:0];
        return CAP_BASE + {3'd0, v};
    endfunction

    function automatic logic [7:0] math_char(input logic [15:0] r);
        return MATH_TAB[r[2:0]];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR, taps 16,14,13,11, loads seed on reset
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (en) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/str_gen.sv
// rtl/str_gen.sv - framed digit/symbol/capital string generator with golden verdict
module str_gen
    import evm_str_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic [2:0] cfg_num_len,
    input  logic [2:0] cfg_cap_len,
    input  logic       cfg_err_en,
    input  logic [3:0] cfg_err_pos,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       expect_ok
);

    state_t      state, state_next;
    logic [2:0]  num_len, cap_len;
    logic        err_en;
    logic [3:0]  err_pos;
    logic [3:0]  idx;
    logic [15:0] r;
    logic        xfer, payload, start_acc, inject_pred, ok_pred;
    logic [7:0]  raw_char;

    assign tx_valid  = (state != S_IDLE);
    assign busy      = tx_valid;
    assign xfer      = tx_valid && tx_ready;
    assign payload   = (state == S_DIG) || (state == S_OP) || (state == S_CAP);
    assign start_acc = (state == S_IDLE) && cfg_start;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (xfer && payload),
        .seed (SEED),
        .q    (r)
    );

    // Injection happens only if the error index falls inside the payload
    assign inject_pred = cfg_err_en &&
        ({1'b0, cfg_err_pos} < ({2'b0, cfg_num_len} + {2'b0, cfg_cap_len} + 5'd1));
    assign ok_pred = (cfg_num_len >= NUM_MIN) && (cfg_num_len <= NUM_MAX) &&
                     (cfg_cap_len >= CAP_MIN) && (cfg_cap_len <= CAP_MAX) &&
                     !inject_pred;

    always_comb begin
        raw_char   = NUL;
        state_next = state;
        case (state)
            S_IDLE: if (cfg_start) state_next = S_SOF;
            S_SOF:  if (xfer) state_next = (num_len != 3'd0) ? S_DIG : S_OP;
            S_DIG: begin
                raw_char = digit_char(r);
                if (xfer && (idx == {1'b0, num_len} - 4'd1)) state_next = S_OP;
            end
            S_OP: begin
                raw_char = math_char(r);
                if (xfer) state_next = (cap_len != 3'd0) ? S_CAP : S_EOF;
            end
            S_CAP: begin
                raw_char = cap_char(r);
                if (xfer && (idx == {1'b0, num_len} + {1'b0, cap_len})) state_next = S_EOF;
            end
            S_EOF:  if (xfer) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        tx_data = (payload && err_en && (idx == err_pos)) ? ERR_CHAR : raw_char;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            num_len   <= 3'd0;
            cap_len   <= 3'd0;
            err_en    <= 1'b0;
            err_pos   <= 4'd0;
            idx       <= 4'd0;
            done      <= 1'b0;
            expect_ok <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == S_EOF) && xfer;
            if (start_acc) begin
                num_len   <= cfg_num_len;
                cap_len   <= cfg_cap_len;
                err_en    <= cfg_err_en;
                err_pos   <= cfg_err_pos;
                idx       <= 4'd0;
                expect_ok <= ok_pred;
            end else if (xfer && payload) begin
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_str_gen.sv
// tb/tb_str_gen.sv - randomized self-checking bench for str_gen against a string-level model
module tb_str_gen;

    localparam logic [15:0] SEED_V = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic [2:0] cfg_num_len = 3'd0;
    logic [2:0] cfg_cap_len = 3'd0;
    logic       cfg_err_en = 1'b0;
    logic [3:0] cfg_err_pos = 4'd0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       expect_ok;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_lfsr;
    logic [7:0]  exp_q[$];
    logic        exp_ok;
    logic [7:0]  math_tab [8] = '{"+", "-", "*", "/", "\\", "=", "<", ">"};

    str_gen dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_num_len (cfg_num_len),
        .cfg_cap_len (cfg_cap_len),
        .cfg_err_en  (cfg_err_en),
        .cfg_err_pos (cfg_err_pos),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .expect_ok   (expect_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole expected frame for one string, plus the verdict
    task automatic build_expected(input int num, input int cap, input bit een, input int epos);
        int plen;
        int v;
        logic [7:0] b;
        plen = num + cap + 1;
        exp_q.delete();
        exp_q.push_back(8'h00);
        for (int i = 0; i < plen; i++) begin
            if (i < num) begin
                b = 8'(48 + (m_lfsr % 8));
            end else if (i == num) begin
                b = math_tab[m_lfsr % 8];
            end else begin
                v = m_lfsr % 32;
                if (v >= 26) v -= 26;
                b = 8'(65 + v);
            end
            if (een && i == epos) b = 8'h23;
            exp_q.push_back(b);
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        exp_q.push_back(8'h00);
        exp_ok = (num >= 3 && num <= 5 && cap >= 1 && cap <= 4) && !(een && epos < plen);
    endtask

    // Entered and left on a negedge; leaves in the done cycle so a following call is back-to-back
    task automatic run_string(input int num, input int cap, input bit een, input int epos,
                              input bit stall, input bit noise);
        int k = 0;
        int cyc = 0;
        bit stalled = 0;
        bit rdy;
        logic [7:0] held = 8'h00;
        build_expected(num, cap, een, epos);
        cfg_num_len = 3'(num);
        cfg_cap_len = 3'(cap);
        cfg_err_en  = een;
        cfg_err_pos = 4'(epos);
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("sof_valid", 32'(tx_valid), 1);
        chk("sof_busy", 32'(busy), 1);
        chk("sof_done", 32'(done), 0);
        while (k < exp_q.size() && cyc < 300) begin
            if (noise) begin
                cfg_num_len = 3'($urandom);
                cfg_cap_len = 3'($urandom);
                cfg_err_en  = 1'($urandom);
                cfg_err_pos = 4'($urandom);
                cfg_start   = ($urandom_range(0, 5) == 0);
            end
            chk("valid", 32'(tx_valid), 1);
            if (stalled) chk("stall_hold", 32'(tx_data), 32'(held));
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            tx_ready = rdy;
            if (rdy) begin
                chk($sformatf("byte%0d", k), 32'(tx_data), 32'(exp_q[k]));
                k++;
                stalled = 0;
            end else begin
                held = tx_data;
                stalled = 1;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready  = 1'b0;
        cfg_start = 1'b0;
        chk("frame_len", k, exp_q.size());
        chk("done_pulse", 32'(done), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_valid", 32'(tx_valid), 0);
        chk("expect_ok", 32'(expect_ok), 32'(exp_ok));
        if (!stall) chk("cycles", cyc, num + cap + 3);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        chk("idle_done", 32'(done), 0);
        chk("idle_valid", 32'(tx_valid), 0);
        chk("ok_hold", 32'(expect_ok), 32'(exp_ok));
    endtask

    initial begin
        m_lfsr = SEED_V;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ok", 32'(expect_ok), 0);
        rst = 1'b0;

        run_string(3, 2, 0, 0, 0, 0);
        idle(1);
        run_string(6, 1, 0, 0, 0, 0);
        run_string(0, 0, 0, 0, 0, 0);
        run_string(4, 3, 1, 4, 0, 0);
        run_string(4, 3, 1, 12, 0, 0);
        idle(2);
        run_string(7, 7, 1, 14, 0, 1);

        for (int i = 0; i < 12; i++) begin
            run_string($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
                       $urandom_range(0, 15), 1, 1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        // Abort a string in the capital run, then the next string must restart from SEED
        build_expected(5, 5, 0, 0);
        cfg_num_len = 3'd5;
        cfg_cap_len = 3'd5;
        cfg_err_en  = 1'b0;
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        tx_ready  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("abort_byte%0d", k), 32'(tx_data), 32'(exp_q[k]));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b0;
        chk("abort_valid", 32'(tx_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ok", 32'(expect_ok), 0);
        chk("abort_data", 32'(tx_data), 0);
        m_lfsr = SEED_V;
        run_string(3, 2, 0, 0, 0, 0);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
